time_field_setter: RTL and testbench
====================================

// Module: time_field_setter
// PURPOSE
//  Parametrised set-mode controller for clock/calendar/alarm fields (sec/min/hour/day/...).
//  Steps through NUM_FIELDS fields and increments the selected copy with per-field min/max wrap.
//  Commits each field to the counter bank with a one-cycle load strobe.
//  Sits between the debounced user buttons and the timekeeping counter bank.
// PARAMETERS
//  NUM_FIELDS   3     number of settable fields, >=1
//  FIELD_W      6     bit width of each field value
//  SEL_W        2     width of set_sel, >= clog2(NUM_FIELDS), min 1
//  TIMEOUT_CYC  1000  idle cycles in EDIT before abort
//  BLINK_CYC    50    half-period of blink, in cycles
//  HOLD_CYC     100   auto-repeat initial delay (AUTO_REPEAT_EN only)
//  REPEAT_CYC   20    auto-repeat interval (AUTO_REPEAT_EN only)
// PORTS
//  clk       in   1                    system clock, all logic on posedge
//  rst_n     in   1                    async active-low reset
//  mode_btn  in   1                    debounced one-cycle pulse: enter / next field
//  inc_btn   in   1                    debounced level: increment button pressed
//  cur_val   in   NUM_FIELDS*FIELD_W   live field values, field i at [i*FIELD_W +: FIELD_W]
//  min_val   in   NUM_FIELDS*FIELD_W   per-field minimum (inclusive), same packing
//  max_val   in   NUM_FIELDS*FIELD_W   per-field maximum (inclusive), same packing
//  set_sel   out  SEL_W                index of field being edited / loaded
//  set_val   out  FIELD_W              edit value; valid when set_load=1
//  set_load  out  1                    one-cycle strobe: counter[set_sel] <= set_val
//  busy      out  1                    high in EDIT/COMMIT
//  blink     out  1                    display blink for the selected field
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; set_sel=0; set_val=0; set_load=0; busy=0; blink=0;
//    all counters cleared. Reset mid-edit aborts and issues no load.
//  All outputs are registered.
//  States: IDLE, EDIT, COMMIT.
//  IDLE: inc_btn ignored.
//    mode_btn -> EDIT, sel=0, edit=cur_val[0], busy=1 next cycle.
//  EDIT:
//    inc edge (inc_btn rising, internally registered) -> edit = (edit>=max || edit<min) ? min : edit+1.
//    mode_btn -> COMMIT.
//    mode_btn and inc edge in the same cycle: mode wins; increment dropped.
//    Timeout counter clears on mode_btn or while inc_btn=1.
//    Timeout reaching TIMEOUT_CYC -> IDLE, no set_load; earlier commits stand.
//  COMMIT (exactly 1 cycle): set_load=1, set_val=edit, set_sel=sel. Strobe appears the cycle after mode_btn is sampled.
//    Next state: if sel==NUM_FIELDS-1 -> IDLE (busy=0 next cycle);
//    else sel+1, edit=cur_val[sel+1], -> EDIT.
//    mode_btn/inc_btn during COMMIT are ignored.
//  blink: toggles every BLINK_CYC cycles in EDIT, starting at 1 on EDIT entry; 0 in IDLE/COMMIT.
//  set_val tracks edit continuously in EDIT; arithmetic is FIELD_W wide with no overflow beyond max.
//  min>max for a field: edit is forced to min on every increment.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    while inc_btn is held in EDIT, a cycle counter starts at the press edge.
//    Extra increment when the counter reaches HOLD_CYC, then every REPEAT_CYC cycles.
//    Release clears the counter.
//  AUTO_REPEAT_EN undefined: only the rising edge increments; HOLD_CYC/REPEAT_CYC unused; no repeat counter.
// TESTING
//  Reset: assert rst_n=0 mid-EDIT with edit=13 -> all outputs 0 immediately; no set_load after release; inc in IDLE -> no change.
//  Single field: cur field0=10, min 0, max 59; mode, 3 inc edges, mode -> set_load 1 cycle, sel=0, val=13; then sel=1, set_val=cur field1.
//  Wrap: max 59, cur 58, 2 incs -> 0. min 1, max 31, cur 31, inc -> 1. cur 0 with min 1, inc -> 1.
//  Full pass (3 fields) -> three set_load pulses, sel 0,1,2; busy=0 the cycle after the 3rd; blink=0.
//  Timeout: enter EDIT, no input for 1000 cycles -> IDLE, busy=0, no set_load. Same-cycle mode+inc on val 7 -> commits 7.
//  AUTO_REPEAT_EN: cur 0, hold inc_btn high for 141 cycles -> edit=4 (edge, +100, +120, +140); macro off -> edit=1.

Source files
------------

// File: rtl/time_field_setter.sv
// Set-mode controller: walks NUM_FIELDS time fields, increments the edited copy with
// per-field min/max wrap and commits each with a one-cycle load strobe. Macro: AUTO_REPEAT_EN.
module time_field_setter #(
    parameter int NUM_FIELDS  = 3,
    parameter int FIELD_W     = 6,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int BLINK_CYC   = 50
`ifdef AUTO_REPEAT_EN
    ,
    parameter int HOLD_CYC    = 100,
    parameter int REPEAT_CYC  = 20
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode_btn,
    input  logic                          inc_btn,
    input  logic [NUM_FIELDS*FIELD_W-1:0] cur_val,
    input  logic [NUM_FIELDS*FIELD_W-1:0] min_val,
    input  logic [NUM_FIELDS*FIELD_W-1:0] max_val,
    output logic [SEL_W-1:0]              set_sel,
    output logic [FIELD_W-1:0]            set_val,
    output logic                          set_load,
    output logic                          busy,
    output logic                          blink
);

    // state     | meaning
    // ST_IDLE   | waiting for mode_btn, inc_btn ignored
    // ST_EDIT   | editing field set_sel, value in set_val, blink running
    // ST_COMMIT | one-cycle load strobe for field set_sel

    typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_t;

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [BL_W-1:0]  BL_LOAD  = BL_W'(BLINK_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_FIELDS - 1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   sel_nx, sel_inc;
    logic [FIELD_W-1:0] edit_nx;
    logic [TO_W-1:0]    to_cnt, to_nx;
    logic [BL_W-1:0]    blink_cnt, blink_cnt_nx;
    logic               blink_nx;
    logic               inc_q, inc_edge, rpt_fire, do_inc;

    logic [FIELD_W-1:0] cur_f [NUM_FIELDS];
    logic [FIELD_W-1:0] min_f [NUM_FIELDS];
    logic [FIELD_W-1:0] max_f [NUM_FIELDS];

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_unpack
        assign cur_f[i] = cur_val[i*FIELD_W +: FIELD_W];
        assign min_f[i] = min_val[i*FIELD_W +: FIELD_W];
        assign max_f[i] = max_val[i*FIELD_W +: FIELD_W];
    end

    assign inc_edge = inc_btn & ~inc_q;
    assign sel_inc  = set_sel + SEL_W'(1);

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic             rpt_on, rpt_on_nx;
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;

    // Counter measures the held time since the press edge; any release disarms it.
    assign rpt_fire = rpt_on & inc_btn & ~inc_edge & (rpt_cnt == '0);

    always_comb begin
        rpt_on_nx  = 1'b0;
        rpt_cnt_nx = rpt_cnt;
        if (state == ST_EDIT && !mode_btn && inc_btn) begin
            if (inc_edge) begin
                rpt_on_nx  = 1'b1;
                rpt_cnt_nx = RPT_W'(HOLD_CYC - 1);
            end else if (rpt_on) begin
                rpt_on_nx  = 1'b1;
                rpt_cnt_nx = (rpt_cnt == '0) ? RPT_W'(REPEAT_CYC - 1) : rpt_cnt - RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_on  <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            rpt_on  <= rpt_on_nx;
            rpt_cnt <= rpt_cnt_nx;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        sel_nx       = set_sel;
        edit_nx      = set_val;
        to_nx        = to_cnt;
        blink_nx     = 1'b0;
        blink_cnt_nx = blink_cnt;
        do_inc       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mode_btn) begin
                    state_nx = ST_EDIT;
                    sel_nx   = '0;
                    edit_nx  = cur_f[0];
                end
            end
            ST_EDIT: begin
                if (mode_btn) begin
                    state_nx = ST_COMMIT;
                end else begin
                    do_inc = inc_edge | rpt_fire;
                    if (inc_btn)             to_nx = TO_LOAD;
                    else if (to_cnt == '0)   state_nx = ST_IDLE;
                    else                     to_nx = to_cnt - TO_W'(1);
                end
            end
            ST_COMMIT: begin
                if (set_sel == LAST_SEL) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_EDIT;
                    sel_nx   = sel_inc;
                    edit_nx  = cur_f[sel_inc];
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Out-of-range values (including min > max) snap to min.
        if (do_inc) begin
            if (set_val >= max_f[set_sel] || set_val < min_f[set_sel])
                edit_nx = min_f[set_sel];
            else
                edit_nx = set_val + FIELD_W'(1);
        end

        if (state_nx == ST_EDIT) begin
            if (state != ST_EDIT) begin
                to_nx        = TO_LOAD;
                blink_nx     = 1'b1;
                blink_cnt_nx = BL_LOAD;
            end else if (blink_cnt == '0) begin
                blink_nx     = ~blink;
                blink_cnt_nx = BL_LOAD;
            end else begin
                blink_nx     = blink;
                blink_cnt_nx = blink_cnt - BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            set_sel   <= '0;
            set_val   <= '0;
            set_load  <= 1'b0;
            busy      <= 1'b0;
            blink     <= 1'b0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            inc_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            set_sel   <= sel_nx;
            set_val   <= edit_nx;
            set_load  <= (state_nx == ST_COMMIT);
            busy      <= (state_nx != ST_IDLE);
            blink     <= blink_nx;
            to_cnt    <= to_nx;
            blink_cnt <= blink_cnt_nx;
            inc_q     <= inc_btn;
        end
    end

endmodule

// File: tb/tb_time_field_setter.sv
// Randomized self-checking bench for time_field_setter with a cycle-level behavioural model
// plus directed literal checks (reset, wrap, timeout, blink, commit, auto-repeat).
module tb_time_field_setter;
    localparam int N  = 3;
    localparam int W  = 6;
    localparam int SW = 2;
    localparam int TO = 1000;
    localparam int BL = 50;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD = 100;
    localparam int RPT  = 20;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mode_btn = 1'b0;
    logic inc_btn = 1'b0;
    logic [N*W-1:0] cur_val = '0;
    logic [N*W-1:0] min_val = '0;
    logic [N*W-1:0] max_val = '0;
    logic [SW-1:0]  set_sel;
    logic [W-1:0]   set_val;
    logic           set_load, busy, blink;

    int n_chk = 0;
    int n_pass = 0;
    int n_loads = 0;

    time_field_setter dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .cur_val(cur_val), .min_val(min_val), .max_val(max_val),
        .set_sel(set_sel), .set_val(set_val), .set_load(set_load),
        .busy(busy), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int fld(input logic [N*W-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    task automatic set_field(input int i, input int c, input int mn, input int mx);
        cur_val[i*W +: W] = W'(c);
        min_val[i*W +: W] = W'(mn);
        max_val[i*W +: W] = W'(mx);
    endtask

    // Behavioural model: mode 0=idle, 1=edit, 2=commit; k = cycles since edit entry.
    int m_st = 0, m_sel = 0, m_edit = 0, m_idle = 0, m_k = 0, m_prev = 0, m_rep_on = 0, m_j = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_sel = 0; m_edit = 0; m_idle = 0; m_k = 0; m_prev = 0; m_rep_on = 0; m_j = 0;
        end else begin
            bit rise, fire;
            int mn, mx;
            rise = inc_btn && (m_prev == 0);
            fire = 0;
            case (m_st)
                0: if (mode_btn) begin
                    m_st = 1; m_sel = 0; m_edit = fld(cur_val, 0); m_idle = 0; m_k = 0; m_rep_on = 0;
                end
                1: if (mode_btn) begin
                    m_st = 2; m_rep_on = 0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (rise) begin m_rep_on = 1; m_j = 0; end
                    else if (inc_btn && m_rep_on != 0) begin
                        m_j++;
                        fire = (m_j == HOLD) || (m_j > HOLD && (m_j - HOLD) % RPT == 0);
                    end
                    if (!inc_btn) m_rep_on = 0;
`endif
                    if (rise || fire) begin
                        mn = fld(min_val, m_sel);
                        mx = fld(max_val, m_sel);
                        m_edit = (m_edit >= mx || m_edit < mn) ? mn : m_edit + 1;
                    end
                    if (inc_btn) m_idle = 0; else m_idle++;
                    if (m_idle == TO) m_st = 0; else m_k++;
                end
                default: if (m_sel == N - 1) m_st = 0;
                else begin
                    m_sel++; m_edit = fld(cur_val, m_sel); m_st = 1; m_idle = 0; m_k = 0;
                end
            endcase
            m_prev = inc_btn ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), (m_st != 0) ? 1 : 0);
            chk("set_load", int'(set_load), (m_st == 2) ? 1 : 0);
            chk("blink", int'(blink), (m_st == 1 && ((m_k / BL) % 2 == 0)) ? 1 : 0);
            if (m_st != 0) begin
                chk("set_sel", int'(set_sel), m_sel);
                chk("set_val", int'(set_val), m_edit);
            end
        end
    end

    always @(posedge clk) if (rst_n && set_load) n_loads++;

    task automatic step(input bit m, input bit i);
        mode_btn = m;
        inc_btn  = i;
        @(negedge clk);
    endtask

    task automatic inc_pulse();
        step(0, 1);
        step(0, 0);
    endtask

    // Called right after the COMMIT of field 0 is visible; walks the remaining fields.
    task automatic finish_pass();
        repeat (N - 1) begin
            step(0, 0);
            step(1, 0);
        end
        step(0, 0);
    endtask

    initial begin
        int loads0, exp_rep;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_val", int'(set_val), 0);
        chk("rst_load", int'(set_load), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_field(i, 10 + 15 * i, 0, 59);

        // inc in IDLE does nothing
        repeat (3) inc_pulse();
        chk("idle_inc_busy", int'(busy), 0);
        chk("idle_inc_val", int'(set_val), 0);

        // single field edit and commit
        loads0 = n_loads;
        step(1, 0);
        chk("enter_val", int'(set_val), 10);
        repeat (3) inc_pulse();
        chk("edit13", int'(set_val), 13);
        step(1, 0);
        chk("commit_load", int'(set_load), 1);
        chk("commit_sel", int'(set_sel), 0);
        chk("commit_val", int'(set_val), 13);
        step(0, 0);
        chk("next_sel", int'(set_sel), 1);
        chk("next_val", int'(set_val), 25);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        chk("last_sel", int'(set_sel), 2);
        step(0, 0);
        chk("pass_busy", int'(busy), 0);
        chk("pass_blink", int'(blink), 0);
        step(0, 0);
        chk("pass_loads", n_loads - loads0, 3);

        // wrap cases
        set_field(0, 58, 0, 59);
        set_field(1, 31, 1, 31);
        set_field(2, 0, 1, 31);
        step(1, 0);
        repeat (2) inc_pulse();
        chk("wrap59", int'(set_val), 0);
        step(1, 0);
        step(0, 0);
        inc_pulse();
        chk("wrap31", int'(set_val), 1);
        step(1, 0);
        step(0, 0);
        step(0, 1);
        chk("below_min", int'(set_val), 1);
        step(0, 0);
        step(1, 0);
        step(0, 0);

        // blink and timeout
        loads0 = n_loads;
        set_field(0, 5, 0, 59);
        step(1, 0);
        chk("blink_k0", int'(blink), 1);
        repeat (49) step(0, 0);
        chk("blink_k49", int'(blink), 1);
        step(0, 0);
        chk("blink_k50", int'(blink), 0);
        repeat (949) step(0, 0);
        chk("to_999", int'(busy), 1);
        step(0, 0);
        chk("to_1000", int'(busy), 0);
        step(0, 0);
        chk("to_loads", n_loads - loads0, 0);

        // mode and inc edge together: mode wins
        set_field(0, 7, 0, 59);
        step(1, 0);
        step(1, 1);
        chk("mode_wins_load", int'(set_load), 1);
        chk("mode_wins_val", int'(set_val), 7);
        finish_pass();

        // reset mid-edit
        set_field(0, 10, 0, 59);
        step(1, 0);
        repeat (3) inc_pulse();
        chk("pre_rst_val", int'(set_val), 13);
        loads0 = n_loads;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_val", int'(set_val), 0);
        chk("mid_rst_sel", int'(set_sel), 0);
        chk("mid_rst_blink", int'(blink), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) inc_pulse();
        chk("post_rst_loads", n_loads - loads0, 0);
        chk("post_rst_val", int'(set_val), 0);

        // held increment
        set_field(0, 0, 0, 59);
        step(1, 0);
        repeat (141) step(0, 1);
`ifdef AUTO_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        chk("hold141", int'(set_val), exp_rep);
        step(0, 0);
        step(1, 0);
        finish_pass();

        // randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            bit m, i;
            if ($urandom_range(0, 199) == 0) begin
                for (int f = 0; f < N; f++) begin
                    int mx;
                    mx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(20, 63);
                    set_field(f, $urandom_range(0, 63), $urandom_range(0, 12), mx);
                end
            end
            if ($urandom_range(0, 1499) == 0) begin
                repeat (1005) step(0, 0);
            end
            m = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 3) == 0) ? !inc_btn : inc_btn;
            step(m, i);
        end
        step(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
